// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register for the RISC-V core.
// Carries a data bundle and a control bundle with a valid/ready handshake,
// optional two-entry skid buffering, synchronous flush, stall hold and
// saturating bubble/stall statistics counters.
module pipe_stage_reg #(
    parameter int DATA_W = 256,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              clr_stats_i,
    output logic [CNT_W-1:0]  bubble_cnt_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    // Main entry (drives the outputs)
    logic              mValid_q, mValid_d;
    logic [DATA_W-1:0] mData_q,  mData_d;
    logic [CTRL_W-1:0] mCtrl_q,  mCtrl_d;

    // Skid entry (only ever filled when SKID is enabled)
    logic              sValid_q, sValid_d;
    logic [DATA_W-1:0] sData_q,  sData_d;
    logic [CTRL_W-1:0] sCtrl_q,  sCtrl_d;

    // Statistics counters
    logic [CNT_W-1:0]  bubbleCnt_q, bubbleCnt_d;
    logic [CNT_W-1:0]  stallCnt_q,  stallCnt_d;

    logic inFire;
    logic outFire;

    // A stall looks exactly like downstream back-pressure.
    assign outFire = mValid_q & out_ready_i & ~stall_i;

    // With the skid entry, in_ready comes straight from a flop so there is no
    // combinational path from out_ready/stall back upstream.
    assign in_ready_o = (SKID != 0) ? ~sValid_q : (~mValid_q | outFire);
    assign inFire     = in_valid_i & in_ready_o;

    assign out_valid_o  = mValid_q;
    assign out_data_o   = mData_q;
    assign out_ctrl_o   = mValid_q ? mCtrl_q : '0;
    assign bubble_cnt_o = bubbleCnt_q;
    assign stall_cnt_o  = stallCnt_q;

    // Entry next-state: flush wins, then FIFO-ordered move/load/clear.
    always_comb begin
        mValid_d = mValid_q;
        mData_d  = mData_q;
        mCtrl_d  = mCtrl_q;
        sValid_d = sValid_q;
        sData_d  = sData_q;
        sCtrl_d  = sCtrl_q;

        if (flush_i) begin
            mValid_d = 1'b0;
            mCtrl_d  = '0;
            sValid_d = 1'b0;
            sCtrl_d  = '0;
        end else if (SKID != 0) begin
            if (!mValid_q) begin
                if (inFire) begin
                    mValid_d = 1'b1;
                    mData_d  = in_data_i;
                    mCtrl_d  = in_ctrl_i;
                end
            end else if (outFire) begin
                if (sValid_q) begin
                    mValid_d = 1'b1;
                    mData_d  = sData_q;
                    mCtrl_d  = sCtrl_q;
                    sValid_d = 1'b0;
                    sCtrl_d  = '0;
                end else if (inFire) begin
                    mValid_d = 1'b1;
                    mData_d  = in_data_i;
                    mCtrl_d  = in_ctrl_i;
                end else begin
                    mValid_d = 1'b0;
                    mCtrl_d  = '0;
                end
            end else if (!sValid_q && inFire) begin
                sValid_d = 1'b1;
                sData_d  = in_data_i;
                sCtrl_d  = in_ctrl_i;
            end
        end else begin
            if (inFire) begin
                mValid_d = 1'b1;
                mData_d  = in_data_i;
                mCtrl_d  = in_ctrl_i;
            end else if (outFire) begin
                mValid_d = 1'b0;
                mCtrl_d  = '0;
            end
        end
    end

    // Counter next-state: clear beats increment, both saturate at all-ones.
    always_comb begin
        bubbleCnt_d = bubbleCnt_q;
        stallCnt_d  = stallCnt_q;
        if (clr_stats_i) begin
            bubbleCnt_d = '0;
            stallCnt_d  = '0;
        end else begin
            if (!mValid_q && (bubbleCnt_q != {CNT_W{1'b1}})) begin
                bubbleCnt_d = bubbleCnt_q + CNT_W'(1);
            end
            if (mValid_q && !outFire && (stallCnt_q != {CNT_W{1'b1}})) begin
                stallCnt_d = stallCnt_q + CNT_W'(1);
            end
        end
    end

    // State registers, cleared asynchronously so a reset drops all beats at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mValid_q    <= 1'b0;
            mData_q     <= '0;
            mCtrl_q     <= '0;
            sValid_q    <= 1'b0;
            sData_q     <= '0;
            sCtrl_q     <= '0;
            bubbleCnt_q <= '0;
            stallCnt_q  <= '0;
        end else begin
            mValid_q    <= mValid_d;
            mData_q     <= mData_d;
            mCtrl_q     <= mCtrl_d;
            sValid_q    <= sValid_d;
            sData_q     <= sData_d;
            sCtrl_q     <= sCtrl_d;
            bubbleCnt_q <= bubbleCnt_d;
            stallCnt_q  <= stallCnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: drives a skid instance (4-bit counters) and a non-skid
// instance (16-bit counters) from shared stimulus and compares both against
// a queue-based model of a FIFO stage of depth 2 / depth 1.
module tb_pipe_stage_reg;
    localparam int DW   = 32;
    localparam int CW   = 8;
    localparam int CNTA = 4;
    localparam int CNTB = 16;
    localparam int MAXA = (1 << CNTA) - 1;
    localparam int MAXB = (1 << CNTB) - 1;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic [CW-1:0] in_ctrl   = '0;
    logic          out_ready = 1'b0;
    logic          stall     = 1'b0;
    logic          flush     = 1'b0;
    logic          clr_stats = 1'b0;

    logic            aInReady, aOutValid, bInReady, bOutValid;
    logic [DW-1:0]   aOutData, bOutData;
    logic [CW-1:0]   aOutCtrl, bOutCtrl;
    logic [CNTA-1:0] aBubble, aStall;
    logic [CNTB-1:0] bBubble, bStall;

    int passCnt  = 0;
    int totalCnt = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(CNTA)) uSkid (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(aInReady), .in_data_i(in_data), .in_ctrl_i(in_ctrl),
        .out_valid_o(aOutValid), .out_ready_i(out_ready), .out_data_o(aOutData), .out_ctrl_o(aOutCtrl),
        .stall_i(stall), .flush_i(flush), .clr_stats_i(clr_stats),
        .bubble_cnt_o(aBubble), .stall_cnt_o(aStall)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(CNTB)) uNoSkid (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(bInReady), .in_data_i(in_data), .in_ctrl_i(in_ctrl),
        .out_valid_o(bOutValid), .out_ready_i(out_ready), .out_data_o(bOutData), .out_ctrl_o(bOutCtrl),
        .stall_i(stall), .flush_i(flush), .clr_stats_i(clr_stats),
        .bubble_cnt_o(bBubble), .stall_cnt_o(bStall)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } beat_t;

    beat_t qA[$];
    beat_t qB[$];
    int mBubA = 0, mStlA = 0, mBubB = 0, mStlB = 0;

    // Reference model: each stage is a FIFO (capacity 2 with skid, 1 without).
    always @(posedge clk or negedge rst_n) begin
        bit    vA, vB, oFireA, oFireB, rdyA, rdyB;
        beat_t nb;
        if (!rst_n) begin
            qA.delete();
            qB.delete();
            mBubA = 0; mStlA = 0; mBubB = 0; mStlB = 0;
        end else begin
            vA     = (qA.size() != 0);
            vB     = (qB.size() != 0);
            oFireA = vA && out_ready && !stall;
            oFireB = vB && out_ready && !stall;
            rdyA   = (qA.size() < 2);
            rdyB   = (qB.size() == 0) || oFireB;
            if (clr_stats) begin
                mBubA = 0; mStlA = 0; mBubB = 0; mStlB = 0;
            end else begin
                if (!vA && mBubA < MAXA) mBubA++;
                if (vA && !oFireA && mStlA < MAXA) mStlA++;
                if (!vB && mBubB < MAXB) mBubB++;
                if (vB && !oFireB && mStlB < MAXB) mStlB++;
            end
            nb = {in_data, in_ctrl};
            if (flush) begin
                qA.delete();
                qB.delete();
            end else begin
                if (oFireA) void'(qA.pop_front());
                if (oFireB) void'(qB.pop_front());
                if (in_valid && rdyA) qA.push_back(nb);
                if (in_valid && rdyB) qB.push_back(nb);
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_ctrl = 8'hFF; in_data = 32'hDEADBEEF; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        totalCnt++; if (aOutValid !== 1'b0 || aOutCtrl !== '0 || aOutData !== '0) $display("[TB] FAIL reset_a_out: got v=%0b c=%h d=%h want 0/00/0", aOutValid, aOutCtrl, aOutData); else passCnt++;
        totalCnt++; if (bOutValid !== 1'b0 || bOutCtrl !== '0 || bOutData !== '0) $display("[TB] FAIL reset_b_out: got v=%0b c=%h d=%h want 0/00/0", bOutValid, bOutCtrl, bOutData); else passCnt++;
        totalCnt++; if (aInReady !== 1'b1 || bInReady !== 1'b1) $display("[TB] FAIL reset_ready: got a=%0b b=%0b want 1/1", aInReady, bInReady); else passCnt++;
        totalCnt++; if (aBubble !== '0 || aStall !== '0 || bBubble !== '0 || bStall !== '0) $display("[TB] FAIL reset_cnt: got %0d %0d %0d %0d want 0", aBubble, aStall, bBubble, bStall); else passCnt++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        totalCnt++; if (aOutValid !== 1'b0 || bOutValid !== 1'b0 || aOutCtrl !== '0 || bOutCtrl !== '0) $display("[TB] FAIL reset_release: got va=%0b vb=%0b want 0/0", aOutValid, bOutValid); else passCnt++;
        @(posedge clk); #1;
        totalCnt++; if (aOutValid !== 1'b1 || aOutCtrl !== 8'hFF || aOutData !== 32'hDEADBEEF) $display("[TB] FAIL first_beat_a: got v=%0b c=%h d=%h want 1/ff/deadbeef", aOutValid, aOutCtrl, aOutData); else passCnt++;
        totalCnt++; if (bOutValid !== 1'b1 || bOutCtrl !== 8'hFF || bOutData !== 32'hDEADBEEF) $display("[TB] FAIL first_beat_b: got v=%0b c=%h d=%h want 1/ff/deadbeef", bOutValid, bOutCtrl, bOutData); else passCnt++;
        @(negedge clk);
        in_valid = 1'b0; in_ctrl = '0;
        @(posedge clk); #1;
        totalCnt++; if (aOutValid !== 1'b0 || bOutValid !== 1'b0) $display("[TB] FAIL first_drain: got a=%0b b=%0b want 0/0", aOutValid, bOutValid); else passCnt++;
        @(negedge clk);
    endtask

    task automatic test_stream();
        int stlA0, stlB0;
        out_ready = 1'b1; stall = 1'b0;
        stlA0 = int'(aStall); stlB0 = int'(bStall);
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1; in_data = DW'(i); in_ctrl = CW'(i);
            @(posedge clk); #1;
            totalCnt++; if (aOutValid !== 1'b1 || aOutData !== DW'(i) || aOutCtrl !== CW'(i) || aInReady !== 1'b1) $display("[TB] FAIL stream_a beat %0d: got v=%0b d=%0d c=%0d r=%0b want 1/%0d/%0d/1", i, aOutValid, aOutData, aOutCtrl, aInReady, i, i); else passCnt++;
            totalCnt++; if (bOutValid !== 1'b1 || bOutData !== DW'(i) || bOutCtrl !== CW'(i) || bInReady !== 1'b1) $display("[TB] FAIL stream_b beat %0d: got v=%0b d=%0d c=%0d r=%0b want 1/%0d/%0d/1", i, bOutValid, bOutData, bOutCtrl, bInReady, i, i); else passCnt++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        totalCnt++; if (aOutValid !== 1'b0 || bOutValid !== 1'b0) $display("[TB] FAIL stream_drain: got a=%0b b=%0b want 0/0", aOutValid, bOutValid); else passCnt++;
        totalCnt++; if (int'(aStall) !== stlA0 || int'(bStall) !== stlB0) $display("[TB] FAIL stream_stallcnt: got a=%0d b=%0d want %0d/%0d", aStall, bStall, stlA0, stlB0); else passCnt++;
        @(negedge clk);
    endtask

    task automatic test_skid_backpressure();
        logic [DW-1:0] dv [3];
        logic [CW-1:0] cv [3];
        dv[0] = 32'hA0A00001; dv[1] = 32'hB0B00002; dv[2] = 32'hC0C00003;
        cv[0] = 8'h11;        cv[1] = 8'h22;        cv[2] = 8'h33;
        out_ready = 1'b0; stall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = dv[k]; in_ctrl = cv[k];
            @(posedge clk); #1;
            totalCnt++; if (aOutValid !== 1'b1 || aOutData !== dv[0] || aOutCtrl !== cv[0]) $display("[TB] FAIL skid_hold cyc %0d: got v=%0b d=%h want 1/%h", k, aOutValid, aOutData, dv[0]); else passCnt++;
            totalCnt++; if (aInReady !== (k == 0)) $display("[TB] FAIL skid_ready cyc %0d: got %0b want %0b", k, aInReady, (k == 0)); else passCnt++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        totalCnt++; if (aOutValid !== 1'b1 || aOutData !== dv[1] || aOutCtrl !== cv[1] || aInReady !== 1'b1) $display("[TB] FAIL skid_release_b: got v=%0b d=%h r=%0b want 1/%h/1", aOutValid, aOutData, aInReady, dv[1]); else passCnt++;
        @(negedge clk);
        @(posedge clk); #1;
        totalCnt++; if (aOutValid !== 1'b1 || aOutData !== dv[2] || aOutCtrl !== cv[2]) $display("[TB] FAIL skid_release_c: got v=%0b d=%h want 1/%h", aOutValid, aOutData, dv[2]); else passCnt++;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        totalCnt++; if (aOutValid !== 1'b0 || aOutCtrl !== '0) $display("[TB] FAIL skid_empty: got v=%0b c=%h want 0/00", aOutValid, aOutCtrl); else passCnt++;
        @(negedge clk);
    endtask

    task automatic test_stall();
        in_valid = 1'b1; in_data = 32'h5EED5EED; in_ctrl = 8'h5A;
        out_ready = 1'b1; stall = 1'b0; clr_stats = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        in_valid = 1'b0; clr_stats = 1'b0; stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            totalCnt++; if (aOutValid !== 1'b1 || aOutData !== 32'h5EED5EED || aOutCtrl !== 8'h5A) $display("[TB] FAIL stall_hold_a cyc %0d: got v=%0b d=%h c=%h want 1/5eed5eed/5a", k, aOutValid, aOutData, aOutCtrl); else passCnt++;
            totalCnt++; if (bOutValid !== 1'b1 || bOutData !== 32'h5EED5EED || bOutCtrl !== 8'h5A) $display("[TB] FAIL stall_hold_b cyc %0d: got v=%0b d=%h c=%h want 1/5eed5eed/5a", k, bOutValid, bOutData, bOutCtrl); else passCnt++;
            @(negedge clk);
        end
        totalCnt++; if (aStall !== 4'd4 || bStall !== 16'd4) $display("[TB] FAIL stall_cnt: got a=%0d b=%0d want 4/4", aStall, bStall); else passCnt++;
        stall = 1'b0;
        @(posedge clk); #1;
        totalCnt++; if (aOutValid !== 1'b0 || bOutValid !== 1'b0) $display("[TB] FAIL stall_release: got a=%0b b=%0b want 0/0", aOutValid, bOutValid); else passCnt++;
        @(negedge clk);
    endtask

    task automatic test_flush();
        out_ready = 1'b0; stall = 1'b0; in_valid = 1'b1; in_data = 32'h0000F001; in_ctrl = 8'hE1;
        @(posedge clk); @(negedge clk);
        in_data = 32'h0000F002; in_ctrl = 8'hE2;
        @(posedge clk); #1;
        totalCnt++; if (aInReady !== 1'b0 || aOutData !== 32'h0000F001) $display("[TB] FAIL flush_setup: got r=%0b d=%h want 0/0000f001", aInReady, aOutData); else passCnt++;
        @(negedge clk);
        flush = 1'b1; out_ready = 1'b1; in_data = 32'h0000F003; in_ctrl = 8'hE3;
        @(posedge clk); #1;
        totalCnt++; if (aOutValid !== 1'b0 || aOutCtrl !== '0 || aInReady !== 1'b1) $display("[TB] FAIL flush_a: got v=%0b c=%h r=%0b want 0/00/1", aOutValid, aOutCtrl, aInReady); else passCnt++;
        totalCnt++; if (bOutValid !== 1'b0 || bOutCtrl !== '0 || bInReady !== 1'b1) $display("[TB] FAIL flush_b: got v=%0b c=%h r=%0b want 0/00/1", bOutValid, bOutCtrl, bInReady); else passCnt++;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            totalCnt++; if (aOutValid !== 1'b0 || bOutValid !== 1'b0) $display("[TB] FAIL flush_ghost cyc %0d: got a=%0b b=%0b want 0/0", k, aOutValid, bOutValid); else passCnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_saturate();
        in_valid = 1'b0; clr_stats = 1'b1;
        @(posedge clk); @(negedge clk);
        clr_stats = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        totalCnt++; if (aBubble !== 4'd15 || bBubble !== 16'd20) $display("[TB] FAIL bubble_sat: got a=%0d b=%0d want 15/20", aBubble, bBubble); else passCnt++;
        @(negedge clk);
        clr_stats = 1'b1;
        @(posedge clk); #1;
        totalCnt++; if (aBubble !== '0 || bBubble !== '0 || aStall !== '0 || bStall !== '0) $display("[TB] FAIL clr_stats: got %0d %0d %0d %0d want 0", aBubble, bBubble, aStall, bStall); else passCnt++;
        @(negedge clk);
        clr_stats = 1'b0;
    endtask

    task automatic test_random();
        logic          eV, eR;
        logic [CW-1:0] eC;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = DW'($urandom);
            in_ctrl   = CW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            stall     = ($urandom_range(0, 4) == 0);
            flush     = ($urandom_range(0, 24) == 0);
            clr_stats = ($urandom_range(0, 39) == 0);
            @(posedge clk); #1;
            eV = (qA.size() != 0);
            eC = eV ? qA[0].c : '0;
            eR = (qA.size() < 2);
            totalCnt++; if (aOutValid !== eV || aOutCtrl !== eC || aInReady !== eR) $display("[TB] FAIL rand_a_hs cyc %0d: got v=%0b c=%h r=%0b want %0b/%h/%0b", i, aOutValid, aOutCtrl, aInReady, eV, eC, eR); else passCnt++;
            if (eV) begin
                totalCnt++; if (aOutData !== qA[0].d) $display("[TB] FAIL rand_a_data cyc %0d: got %h want %h", i, aOutData, qA[0].d); else passCnt++;
            end
            totalCnt++; if (int'(aBubble) !== mBubA || int'(aStall) !== mStlA) $display("[TB] FAIL rand_a_cnt cyc %0d: got %0d/%0d want %0d/%0d", i, aBubble, aStall, mBubA, mStlA); else passCnt++;
            eV = (qB.size() != 0);
            eC = eV ? qB[0].c : '0;
            eR = !eV || (out_ready && !stall);
            totalCnt++; if (bOutValid !== eV || bOutCtrl !== eC || bInReady !== eR) $display("[TB] FAIL rand_b_hs cyc %0d: got v=%0b c=%h r=%0b want %0b/%h/%0b", i, bOutValid, bOutCtrl, bInReady, eV, eC, eR); else passCnt++;
            if (eV) begin
                totalCnt++; if (bOutData !== qB[0].d) $display("[TB] FAIL rand_b_data cyc %0d: got %h want %h", i, bOutData, qB[0].d); else passCnt++;
            end
            totalCnt++; if (int'(bBubble) !== mBubB || int'(bStall) !== mStlB) $display("[TB] FAIL rand_b_cnt cyc %0d: got %0d/%0d want %0d/%0d", i, bBubble, bStall, mBubB, mStlB); else passCnt++;
            @(negedge clk);
        end
        in_valid = 1'b0; stall = 1'b0; flush = 1'b0; clr_stats = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; in_data = 32'h0BADF00D; in_ctrl = 8'hC3; out_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        totalCnt++; if (aOutValid !== 1'b0 || aOutCtrl !== '0 || aOutData !== '0 || aInReady !== 1'b1) $display("[TB] FAIL async_rst_a: got v=%0b c=%h d=%h r=%0b want 0/00/0/1", aOutValid, aOutCtrl, aOutData, aInReady); else passCnt++;
        totalCnt++; if (bOutValid !== 1'b0 || bOutCtrl !== '0 || bOutData !== '0 || bInReady !== 1'b1) $display("[TB] FAIL async_rst_b: got v=%0b c=%h d=%h r=%0b want 0/00/0/1", bOutValid, bOutCtrl, bOutData, bInReady); else passCnt++;
        totalCnt++; if (aBubble !== '0 || aStall !== '0 || bBubble !== '0 || bStall !== '0) $display("[TB] FAIL async_rst_cnt: got %0d %0d %0d %0d want 0", aBubble, aStall, bBubble, bStall); else passCnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        totalCnt++; if (aOutValid !== 1'b0 || bOutValid !== 1'b0) $display("[TB] FAIL async_rst_lost: got a=%0b b=%0b want 0/0", aOutValid, bOutValid); else passCnt++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_skid_backpressure();
        test_stall();
        test_flush();
        test_saturate();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the RISC-V pipeline, the generalised replacement for the fixed ID/EX-style latches. It carries a data bundle and a control bundle between stages with a valid/ready handshake, optional 2-entry skid buffering, synchronous flush, and stall hold. Control bits are forced to zero on every bubble so downstream regwrite/memwrite/memread can never fire spuriously. Saturating bubble/stall counters provide pipeline performance statistics.

## Interface
- DATA_W, 256, width of data bundle (operands, imm, pc, register ids, func fields)
- CTRL_W, 8, width of control bundle (aluop, alusrc, mem/reg enables)
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry, combinational in_ready
- CNT_W, 16, width of statistics counters
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat
- in_data  in  DATA_W  upstream data bundle
- in_ctrl  in  CTRL_W  upstream control bundle
- out_valid  out  1  beat presented downstream
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  held data bundle
- out_ctrl  out  CTRL_W  held control bundle; 0 whenever out_valid=0
- stall  in  1  hazard hold; while 1, output handshake is suppressed (acts as out_ready=0)
- flush  in  1  synchronous kill of all held and incoming beats
- clr_stats  in  1  synchronous clear of both counters
- bubble_cnt  out  CNT_W  cycles with out_valid=0
- stall_cnt  out  CNT_W  cycles with out_valid=1 and no output fire

## Operation
- Storage: main entry M (drives outputs) and, when SKID=1, skid entry S; each has a valid bit, data, ctrl.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready & ~stall.
- SKID=1: in_ready = ~S.valid (registered). SKID=0: in_ready = ~M.valid | out_fire.
- Priority per cycle: flush > normal update.
- Flush: M.valid, S.valid <= 0; M.ctrl, S.ctrl <= 0; data registers hold; any in_fire beat in that cycle is discarded.
- Normal update, SKID=1:
  - M empty: in_fire loads M.
  - M valid, out_fire, S empty: in_fire loads M, else M.valid <= 0 and M.ctrl <= 0.
  - M valid, out_fire, S valid: S moves to M, S.valid <= 0; in_ready rises next cycle.
  - M valid, no out_fire, S empty: in_fire loads S; in_ready falls next cycle.
  - M valid, S valid: no in_fire possible; hold.
- SKID=0: M loads on in_fire; else M cleared (valid, ctrl) on out_fire; else hold.
- Ordering strictly FIFO; no beat duplicated or dropped except by flush.
- Counters: increment by 1 per qualifying cycle, saturate at 2^CNT_W-1; clr_stats clears to 0, taking precedence over increment that cycle; unaffected by flush.

## Timing
- Reset (async): M.valid=S.valid=0, all data/ctrl=0, counters=0 → out_valid=0, out_ctrl=0, out_data=0, in_ready=1.
- Latency: in_fire at edge N → out_valid=1 with that beat after edge N (one cycle) when M empty or out_fire.
- Throughput: one beat/cycle sustained with out_ready=1, stall=0, both SKID modes.
- SKID=1: in_ready is a pure flop output, no combinational path from out_ready/stall.
- flush asserted at edge N: out_valid=0, out_ctrl=0 after edge N; in_ready=1 after edge N.
- Reset mid-transfer: all beats lost, outputs return to reset values immediately (asynchronous).

## Test plan
- Reset with in_valid=1, in_ctrl=8'hFF → out_valid=0, out_ctrl=0, out_data=0, in_ready=1, counters=0 until first edge after rst_n release.
- Stream beats 1..10 with out_ready=1 (SKID=1 and 0) → outputs 1..10 in order, one per cycle, 1-cycle latency, stall_cnt unchanged.
- SKID=1, out_ready=0 for 3 cycles while sending A,B,C → M=A, S=B, in_ready=0 from cycle after B, C held upstream; release → A,B,C delivered in order.
- stall=1 with out_ready=1, out_valid=1 for 4 cycles → out_data/out_ctrl held, stall_cnt +4, no beat lost.
- flush with M and S valid and concurrent in_fire → next cycle out_valid=0, out_ctrl=0, in_ready=1; none of the three beats ever appears.
- CNT_W=4, idle 20 cycles → bubble_cnt saturates at 15; clr_stats pulse → 0 next cycle.
